wave_sweep_ctrl: RTL and testbench

WAVE_SWEEP_CTRL -- requirements
Module: wave_sweep_ctrl

---
 rtl/wave_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_wave_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sweep_ctrl.sv
// Frequency-code sweep sequencer for a wave generator: manual select, up and up-down sweeps
// with per-code dwell, optional looping, abort and sticky configuration error.
//
// state    | meaning
// IDLE     | manual tracking (mode 00) or holding; waits for start
// RUN_UP   | stepping freq_sel upward toward f_max
// RUN_DOWN | stepping freq_sel downward toward f_min (up-down mode)
// DONE     | one-cycle sweep_done pulse, then back to IDLE
module wave_sweep_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic          loop,
  input  logic [7:0]    manual_sel,
  input  logic [7:0]    f_min,
  input  logic [7:0]    f_max,
  input  logic [7:0]    step,
  input  logic [DW-1:0] dwell,
  output logic [7:0]    freq_sel,
  output logic          freq_upd,
  output logic          busy,
  output logic          sweep_done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    freq_q, freq_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [1:0]    sh_mode_q, sh_mode_d;
  logic          sh_loop_q, sh_loop_d;
  logic [7:0]    sh_fmin_q, sh_fmin_d;
  logic [7:0]    sh_fmax_q, sh_fmax_d;
  logic [7:0]    sh_step_q, sh_step_d;
  logic [DW-1:0] sh_dwell_q, sh_dwell_d;
  logic          upd_q, upd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          upd_force;
  logic          expire;
  logic [8:0]    up_sum;
  logic [7:0]    up_next;
  logic [7:0]    dn_base;
  logic [9:0]    dn_diff;
  logic [7:0]    dn_next;

  // Step arithmetic is one bit wider than the code so it saturates instead of wrapping.
  always_comb begin
    expire  = (cnt_q == sh_dwell_q - DW'(1));
    up_sum  = {1'b0, freq_q} + {1'b0, sh_step_q};
    up_next = (up_sum > {1'b0, sh_fmax_q}) ? sh_fmax_q : up_sum[7:0];
    dn_base = (state_q == RUN_UP) ? sh_fmax_q : freq_q;
    dn_diff = {2'b00, dn_base} - {2'b00, sh_step_q};
    dn_next = (dn_diff[9] || (dn_diff[7:0] < sh_fmin_q)) ? sh_fmin_q : dn_diff[7:0];
  end

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    cnt_d      = cnt_q;
    sh_mode_d  = sh_mode_q;
    sh_loop_d  = sh_loop_q;
    sh_fmin_d  = sh_fmin_q;
    sh_fmax_d  = sh_fmax_q;
    sh_step_d  = sh_step_q;
    sh_dwell_d = sh_dwell_q;
    err_d      = err_q;
    upd_force  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (mode == 2'b01 || mode == 2'b10)) begin
          sh_mode_d  = mode;
          sh_loop_d  = loop;
          sh_fmin_d  = f_min;
          sh_fmax_d  = f_max;
          sh_step_d  = step;
          sh_dwell_d = dwell;
          if (f_min > f_max || step == 8'd0 || dwell == '0) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            freq_d    = f_min;
            upd_force = 1'b1;
            cnt_d     = '0;
            state_d   = RUN_UP;
          end
        end else if (mode == 2'b00) begin
          freq_d = manual_sel;
        end
      end
      RUN_UP: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (expire) begin
          cnt_d = '0;
          if (freq_q < sh_fmax_q) begin
            freq_d = up_next;
          end else if (sh_mode_q == 2'b10 && sh_fmin_q != sh_fmax_q) begin
            state_d = RUN_DOWN;
            freq_d  = dn_next;
          end else if (sh_loop_q) begin
            freq_d = sh_fmin_q;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      RUN_DOWN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (expire) begin
          cnt_d = '0;
          if (freq_q > sh_fmin_q) begin
            freq_d = dn_next;
          end else if (sh_loop_q) begin
            state_d = RUN_UP;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    upd_d  = upd_force || (freq_d != freq_q);
    busy_d = (state_d == RUN_UP) || (state_d == RUN_DOWN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      freq_q     <= 8'd0;
      cnt_q      <= '0;
      sh_mode_q  <= 2'b00;
      sh_loop_q  <= 1'b0;
      sh_fmin_q  <= 8'd0;
      sh_fmax_q  <= 8'd0;
      sh_step_q  <= 8'd0;
      sh_dwell_q <= '0;
      upd_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      cnt_q      <= cnt_d;
      sh_mode_q  <= sh_mode_d;
      sh_loop_q  <= sh_loop_d;
      sh_fmin_q  <= sh_fmin_d;
      sh_fmax_q  <= sh_fmax_d;
      sh_step_q  <= sh_step_d;
      sh_dwell_q <= sh_dwell_d;
      upd_q      <= upd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign freq_sel   = freq_q;
  assign freq_upd   = upd_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// Bench for wave_sweep_ctrl: directed and random sweeps compared against a code-list model
// (expected code sequence built arithmetically, each code held dwell cycles).
`timescale 1us/1ns
module tb_wave_sweep_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          loop = 1'b0;
  logic [7:0]    manual_sel = 8'd0;
  logic [7:0]    f_min = 8'd0;
  logic [7:0]    f_max = 8'd0;
  logic [7:0]    step = 8'd0;
  logic [DW-1:0] dwell = '0;
  logic [7:0]    freq_sel;
  logic          freq_upd;
  logic          busy;
  logic          sweep_done;
  logic          err;

  int total = 0;
  int bad = 0;
  int exp_freq = 0;

  wave_sweep_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .loop(loop),
    .manual_sel(manual_sel), .f_min(f_min), .f_max(f_max), .step(step), .dwell(dwell),
    .freq_sel(freq_sel), .freq_upd(freq_upd), .busy(busy), .sweep_done(sweep_done), .err(err)
  );

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Ordered list of codes one non-looping sweep visits.
  task automatic build(input int md, input int fmin, input int fmax, input int stp,
                       output int q[$]);
    int cur;
    q = {};
    cur = fmin;
    q.push_back(cur);
    while (cur < fmax) begin
      cur = (cur + stp > fmax) ? fmax : cur + stp;
      q.push_back(cur);
    end
    if (md == 2 && fmin != fmax) begin
      while (cur > fmin) begin
        cur = (cur - stp < fmin) ? fmin : cur - stp;
        q.push_back(cur);
      end
    end
  endtask

  task automatic scramble_inputs();
    mode       = 2'($urandom_range(0, 3));
    loop       = 1'($urandom_range(0, 1));
    f_min      = 8'($urandom);
    f_max      = 8'($urandom);
    step       = 8'($urandom);
    dwell      = DW'($urandom_range(0, 5));
    manual_sel = 8'($urandom);
    start      = 1'($urandom_range(0, 1));
  endtask

  // stop_at < 0: run to completion; otherwise assert stop after run cycle stop_at.
  task automatic run_sweep(input int md, input int lp, input int fmin, input int fmax,
                           input int stp, input int dw, input int stop_at, input int scr);
    int q[$];
    int n, t, k, code, prev;
    build(md, fmin, fmax, stp, q);
    n = q.size();
    mode = 2'(md); loop = 1'(lp); f_min = 8'(fmin); f_max = 8'(fmax);
    step = 8'(stp); dwell = DW'(dw); stop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    t = (stop_at >= 0) ? stop_at + 1 : n * dw;
    for (int c = 0; c < t; c++) begin
      k    = (c / dw) % n;
      code = q[k];
      prev = (c == 0) ? -1 : q[((c / dw) + n - 1) % n];
      chk("run_freq", freq_sel, code);
      chk("run_busy", busy, 1);
      chk("run_done", sweep_done, 0);
      chk("run_upd", freq_upd, ((c % dw == 0) && (code != prev)) ? 1 : 0);
      if (c == 0) chk("start_err_clr", err, 0);
      exp_freq = code;
      if (scr != 0) scramble_inputs();
      if (c < t - 1) tick();
    end
    if (stop_at >= 0) begin
      stop = 1'b1; start = 1'b1;
      tick();
      chk("stop_freq", freq_sel, exp_freq);
      chk("stop_busy", busy, 0);
      chk("stop_done", sweep_done, 0);
      chk("stop_upd", freq_upd, 0);
      stop = 1'b0; start = 1'b0; mode = 2'b11;
      tick();
      chk("stop_idle_done", sweep_done, 0);
      chk("stop_idle_freq", freq_sel, exp_freq);
    end else begin
      start = 1'b0; mode = 2'b11;
      tick();
      chk("done_pulse", sweep_done, 1);
      chk("done_busy", busy, 0);
      chk("done_freq", freq_sel, exp_freq);
      chk("done_upd", freq_upd, 0);
      tick();
      chk("done_once", sweep_done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_freq", freq_sel, exp_freq);
    end
  endtask

  task automatic bad_start(input int fmin, input int fmax, input int stp, input int dw);
    mode = 2'b01; loop = 1'b0; f_min = 8'(fmin); f_max = 8'(fmax);
    step = 8'(stp); dwell = DW'(dw); start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_set", err, 1);
    chk("err_busy", busy, 0);
    chk("err_freq", freq_sel, exp_freq);
    chk("err_upd", freq_upd, 0);
    tick();
    chk("err_sticky", err, 1);
    chk("err_idle_busy", busy, 0);
  endtask

  initial begin
    int mv, md, fmin, fmax, stp, dw, lp, n, stop_at;
    int q[$];

    manual_sel = 8'h5A;
    #20;
    chk("rst_freq", freq_sel, 0);
    chk("rst_upd", freq_upd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_manual", freq_sel, 8'h5A);
    chk("rel_upd", freq_upd, 1);
    tick();
    chk("manual_same_upd", freq_upd, 0);
    exp_freq = 8'h5A;

    for (int i = 0; i < 16; i++) begin
      mv = (i % 3 == 0) ? exp_freq : $urandom_range(0, 255);
      manual_sel = 8'(mv);
      tick();
      chk("manual_freq", freq_sel, mv);
      chk("manual_upd", freq_upd, (mv != exp_freq) ? 1 : 0);
      exp_freq = mv;
    end

    mode = 2'b01; manual_sel = 8'(exp_freq + 1);
    tick();
    chk("hold_nonmanual", freq_sel, exp_freq);

    mode = 2'b11; f_min = 8'd3; f_max = 8'd9; step = 8'd2; dwell = DW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    chk("mode11_busy", busy, 0);
    chk("mode11_freq", freq_sel, exp_freq);
    mode = 2'b00; manual_sel = 8'd44; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mode00_start_busy", busy, 0);
    chk("mode00_start_freq", freq_sel, 44);
    exp_freq = 44;

    run_sweep(1, 0, 10, 20, 4, 3, -1, 0);
    run_sweep(2, 0, 10, 20, 4, 3, -1, 0);
    run_sweep(1, 0, 250, 255, 10, 2, -1, 0);
    run_sweep(2, 0, 0, 255, 100, 1, -1, 1);
    run_sweep(2, 0, 77, 77, 5, 2, -1, 0);

    bad_start(10, 20, 0, 3);
    run_sweep(1, 0, 10, 20, 4, 3, -1, 0);
    bad_start(30, 20, 4, 3);
    bad_start(10, 20, 4, 0);
    run_sweep(2, 0, 5, 9, 3, 1, -1, 0);

    run_sweep(1, 0, 10, 20, 4, 3, 5, 0);
    run_sweep(1, 1, 10, 20, 4, 3, 40, 0);
    run_sweep(2, 1, 10, 20, 4, 3, 50, 1);
    run_sweep(1, 1, 42, 42, 9, 2, 9, 0);

    mode = 2'b10; loop = 1'b0; f_min = 8'd10; f_max = 8'd20; step = 8'd4; dwell = DW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    chk("pre_rst_freq", freq_sel, 16);
    #20;
    rst_n = 1'b0;
    #1;
    chk("async_rst_freq", freq_sel, 0);
    chk("async_rst_upd", freq_upd, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", sweep_done, 0);
    chk("async_rst_err", err, 0);
    mode = 2'b00; manual_sel = 8'd7;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_manual", freq_sel, 7);
    chk("post_rst_upd", freq_upd, 1);
    chk("post_rst_busy", busy, 0);
    exp_freq = 7;

    for (int i = 0; i < 24; i++) begin
      md   = $urandom_range(1, 2);
      fmin = $urandom_range(0, 255);
      fmax = $urandom_range(fmin, (fmin + 90 > 255) ? 255 : fmin + 90);
      stp  = $urandom_range(1, 60);
      dw   = $urandom_range(1, 4);
      lp   = $urandom_range(0, 1);
      build(md, fmin, fmax, stp, q);
      n = q.size();
      if (lp != 0) stop_at = $urandom_range(0, 3 * n * dw);
      else if ($urandom_range(0, 3) == 0) stop_at = $urandom_range(0, n * dw - 1);
      else stop_at = -1;
      run_sweep(md, lp, fmin, fmax, stp, dw, stop_at, $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
